// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: RV32I funct3 size codes and FSM states.
package lsu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_MERGE = 2'd2,
        ST_WRITE = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: load extraction/extension, sub-word store merge,
// and the illegal/misaligned check for an access.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    input  logic            is_store,
    input  logic [XLEN-1:0] sdata,
    output logic [XLEN-1:0] load_val_c,
    output logic [XLEN-1:0] merged_c,
    output logic            bad_c
);

    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic        legal;
    logic        misaligned;

    always_comb begin
        byte_sh = {offset, 3'b000};
        half_sh = {offset[1], 4'b0000};
        lane_b  = 8'(word >> byte_sh);
        lane_h  = 16'(word >> half_sh);

        load_val_c = word;
        unique case (funct3)
            F3_B:    load_val_c = {{24{lane_b[7]}}, lane_b};
            F3_H:    load_val_c = {{16{lane_h[15]}}, lane_h};
            F3_BU:   load_val_c = {24'h000000, lane_b};
            F3_HU:   load_val_c = {16'h0000, lane_h};
            default: load_val_c = word;
        endcase

        // Sub-word stores keep the untouched lanes from the word just read
        merged_c = sdata;
        unique case (funct3)
            F3_B:    merged_c = (word & ~(32'h0000_00FF << byte_sh))
                              | (XLEN'(sdata[7:0]) << byte_sh);
            F3_H:    merged_c = (word & ~(32'h0000_FFFF << half_sh))
                              | (XLEN'(sdata[15:0]) << half_sh);
            default: merged_c = sdata;
        endcase

        if (is_store) begin
            legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        end else begin
            legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W)
                 || (funct3 == F3_BU) || (funct3 == F3_HU);
        end
        misaligned = ((funct3[1:0] == 2'b01) && offset[0])
                  || ((funct3[1:0] == 2'b10) && (offset != 2'b00));
        bad_c = !legal || misaligned;
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store initiator for a word-only data memory; sub-word stores
// are done as read-modify-write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req,
    input  logic            we,
    input  logic [2:0]      funct3,
    input  logic [N-1:0]    addr,
    input  logic [XLEN-1:0] wdata,
    output logic            ready,
    output logic            done,
    output logic            err,
    output logic [XLEN-1:0] rdata,
    output logic [N-1:0]    mem_A,
    output logic [XLEN-1:0] mem_WD,
    output logic            mem_WE,
    input  logic [XLEN-1:0] mem_RD
);

    lsu_state_t      state_q, state_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [N-1:0]    addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] merge_q, merge_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic            idle;
    logic [1:0]      al_off;
    logic [2:0]      al_f3;
    logic [XLEN-1:0] load_val_c;
    logic [XLEN-1:0] merged_c;
    logic            bad_c;

    assign idle = (state_q == ST_IDLE);

    // In IDLE the aligner judges the incoming request; otherwise the latched one
    assign al_off = idle ? addr[1:0] : addr_q[1:0];
    assign al_f3  = idle ? funct3    : funct3_q;

    lsu_lane_align u_align (
        .word       (mem_RD),
        .offset     (al_off),
        .funct3     (al_f3),
        .is_store   (we),
        .sdata      (wdata_q),
        .load_val_c (load_val_c),
        .merged_c   (merged_c),
        .bad_c      (bad_c)
    );

    always_comb begin
        state_d  = state_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        merge_d  = merge_q;
        rdata_d  = rdata_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    funct3_d = funct3;
                    addr_d   = addr;
                    wdata_d  = wdata;
                    if (bad_c) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else if (!we) begin
                        state_d = ST_LOAD;
                    end else if (funct3 == F3_W) begin
                        merge_d = wdata;
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_MERGE;
                    end
                end
            end
            ST_LOAD: begin
                rdata_d = load_val_c;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            ST_MERGE: begin
                merge_d = merged_c;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            merge_q  <= '0;
            rdata_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            merge_q  <= merge_d;
            rdata_q  <= rdata_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Write enable decodes the state flop so an async reset drops it at once
    assign ready  = idle;
    assign mem_WE = (state_q == ST_WRITE);
    assign done   = done_q;
    assign err    = err_q;
    assign rdata  = rdata_q;
    assign mem_A  = {addr_q[N-1:2], 2'b00};
    assign mem_WD = merge_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit against a byte-addressed reference memory.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [7:0]  mem_A;
    logic [31:0] mem_WD;
    logic        mem_WE;
    logic [31:0] mem_RD;

    logic [31:0] mem [64];
    logic        init_we;
    logic [5:0]  init_idx;
    logic [31:0] init_val;

    logic [7:0]  ref_b [256];
    logic [31:0] last_rd;
    int          n_checks;
    int          n_fail;

    always #5 clk = ~clk;

    load_store_unit #(.N(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .we     (we),
        .funct3 (funct3),
        .addr   (addr),
        .wdata  (wdata),
        .ready  (ready),
        .done   (done),
        .err    (err),
        .rdata  (rdata),
        .mem_A  (mem_A),
        .mem_WD (mem_WD),
        .mem_WE (mem_WE),
        .mem_RD (mem_RD)
    );

    assign mem_RD = mem[mem_A[7:2]];

    always @(posedge clk) begin
        if (init_we) mem[init_idx] <= init_val;
        else if (mem_WE) mem[mem_A[7:2]] <= mem_WD;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [7:0] a);
        logic [7:0] base;
        base = {a[7:2], 2'b00};
        return {ref_b[base + 8'd3], ref_b[base + 8'd2], ref_b[base + 8'd1], ref_b[base]};
    endfunction

    task automatic preload(input logic [5:0] idx, input logic [31:0] val);
        init_we  = 1'b1;
        init_idx = idx;
        init_val = val;
        for (int i = 0; i < 4; i++) ref_b[{idx, 2'b00} + 8'(i)] = 8'(val >> (8 * i));
        @(posedge clk);
        #1 init_we = 1'b0;
    endtask

    // One access, driven at a negedge; returns at the negedge of its done cycle
    task automatic access(input string tag, input logic w, input logic [2:0] f3,
                          input logic [7:0] a, input logic [31:0] wd);
        bit          legal;
        int          size;
        bit          exp_err;
        int          exp_lat;
        int          exp_we_cyc;
        int          lat;
        int          we_cnt;
        int          we_cyc;
        logic [31:0] exp_word;
        logic [31:0] got_wd;
        logic [7:0]  b;
        logic [15:0] h;

        legal   = w ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        size    = 1 << f3[1:0];
        exp_err = !legal || ((int'(a) % size) != 0);

        // Reference: byte-level memory semantics
        if (!exp_err && !w) begin
            b = ref_b[a];
            h = {ref_b[a + 8'd1], ref_b[a]};
            case (f3)
                3'd0:    last_rd = {{24{b[7]}}, b};
                3'd1:    last_rd = {{16{h[15]}}, h};
                3'd4:    last_rd = {24'd0, b};
                3'd5:    last_rd = {16'd0, h};
                default: last_rd = ref_word(a);
            endcase
        end
        if (!exp_err && w) begin
            for (int i = 0; i < size; i++) ref_b[a + 8'(i)] = 8'(wd >> (8 * i));
        end
        exp_word   = ref_word(a);
        exp_lat    = exp_err ? 1 : (w && f3 != 3'd2) ? 3 : 2;
        exp_we_cyc = (!exp_err && w) ? exp_lat - 1 : 0;

        req = 1'b1; we = w; funct3 = f3; addr = a; wdata = wd;
        @(posedge clk);
        #1 req = 1'b0;
        we = $urandom_range(0, 1); funct3 = 3'($urandom); addr = 8'($urandom); wdata = $urandom;

        lat = 0; we_cnt = 0; we_cyc = 0; got_wd = 32'd0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (mem_WE) begin
                we_cnt++;
                we_cyc = k;
                got_wd = mem_WD;
            end
            if (done) begin
                lat = k;
                break;
            end
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " err"}, 32'(err), 32'(exp_err));
        check({tag, " rdata"}, rdata, last_rd);
        check({tag, " we_count"}, 32'(we_cnt), (!exp_err && w) ? 32'd1 : 32'd0);
        check({tag, " we_cycle"}, 32'(we_cyc), 32'(exp_we_cyc));
        if (!exp_err && w) check({tag, " mem_WD"}, got_wd, exp_word);
        check({tag, " ready"}, 32'(ready), 32'd1);
        check({tag, " mem_word"}, mem[a[7:2]], exp_word);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        last_rd  = 32'd0;
        rst = 1'b1; req = 1'b0; we = 1'b0; funct3 = 3'd0; addr = 8'd0; wdata = 32'd0;
        init_we = 1'b0; init_idx = 6'd0; init_val = 32'd0;

        for (int i = 0; i < 64; i++) preload(6'(i), $urandom);
        preload(6'h04, 32'h80FF7F01);
        preload(6'h08, 32'h11223344);

        @(negedge clk);
        check("rst ready", 32'(ready), 32'd1);
        check("rst done", 32'(done), 32'd0);
        check("rst err", 32'(err), 32'd0);
        check("rst rdata", rdata, 32'd0);
        check("rst mem_WE", 32'(mem_WE), 32'd0);
        check("rst mem_A", 32'(mem_A), 32'd0);
        check("rst mem_WD", mem_WD, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        access("LB 13", 1'b0, 3'd0, 8'h13, 32'd0);
        check("LB 13 value", rdata, 32'hFFFFFF80);
        access("LBU 12", 1'b0, 3'd4, 8'h12, 32'd0);
        check("LBU 12 value", rdata, 32'h000000FF);
        access("LH 12", 1'b0, 3'd1, 8'h12, 32'd0);
        check("LH 12 value", rdata, 32'hFFFF80FF);
        access("LHU 10", 1'b0, 3'd5, 8'h10, 32'd0);
        check("LHU 10 value", rdata, 32'h00007F01);
        access("LW 10", 1'b0, 3'd2, 8'h10, 32'd0);
        check("LW 10 value", rdata, 32'h80FF7F01);

        access("SB 21", 1'b1, 3'd0, 8'h21, 32'h000000AB);
        check("SB 21 word", mem[8], 32'h1122AB44);
        access("SH 22", 1'b1, 3'd1, 8'h22, 32'h0000BEEF);
        check("SH 22 word", mem[8], 32'hBEEFAB44);
        access("SW 30", 1'b1, 3'd2, 8'h30, 32'hDEADBEEF);
        access("LW 30", 1'b0, 3'd2, 8'h30, 32'd0);
        check("LW 30 value", rdata, 32'hDEADBEEF);

        access("LW 31", 1'b0, 3'd2, 8'h31, 32'd0);
        access("SH 33", 1'b1, 3'd1, 8'h33, 32'h12345678);
        access("LD f3=3", 1'b0, 3'd3, 8'h10, 32'd0);
        check("err keeps rdata", rdata, 32'hDEADBEEF);

        // Reset during the write cycle of a byte store
        req = 1'b1; we = 1'b1; funct3 = 3'd0; addr = 8'h21; wdata = 32'h00000055;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort mem_WE before", 32'(mem_WE), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("abort mem_WE", 32'(mem_WE), 32'd0);
        check("abort ready", 32'(ready), 32'd1);
        check("abort done", 32'(done), 32'd0);
        check("abort err", 32'(err), 32'd0);
        check("abort rdata", rdata, 32'd0);
        check("abort mem_A", 32'(mem_A), 32'd0);
        check("abort mem_WD", mem_WD, 32'd0);
        last_rd = 32'd0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort word kept", mem[8], 32'hBEEFAB44);
        @(negedge clk);
        access("LW 20 after rst", 1'b0, 3'd2, 8'h20, 32'd0);
        check("LW 20 after rst value", rdata, 32'hBEEFAB44);

        for (int n = 0; n < 300; n++) begin
            logic [2:0] f3r;
            f3r = (n % 4 == 0) ? 3'($urandom) : 3'($urandom_range(0, 2)) | ($urandom_range(0, 1) ? 3'd4 : 3'd0);
            access("rand", 1'($urandom), f3r, 8'($urandom), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Core-side initiator for the word-organised data memory.
- Converts RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into whole-word memory accesses.
- Loads: byte/halfword lane extraction and sign/zero extension.
- Sub-word stores: read-modify-write, because the memory writes whole words only.
- Sits between the execute stage of the multi-cycle core and the data memory port; flags misaligned or illegal accesses without touching memory.

Parameters:
- N, 8, byte-address width; must match the data memory's N.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  access request; sampled only while ready=1.
- we  in  1  1 = store, 0 = load; sampled with req.
- funct3  in  3  RV32I size/sign code; sampled with req.
- addr  in  N  byte address; sampled with req.
- wdata  in  32  store data, right-aligned; sampled with req.
- ready  out  1  unit idle and able to accept req.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; 1 = misaligned or illegal funct3, no memory side effect.
- rdata  out  32  extended load result; holds until the next completed load.
- mem_A  out  N  memory byte address, always word-aligned: {addr_q[N-1:2], 2'b00}.
- mem_WD  out  32  memory write word.
- mem_WE  out  1  memory write enable.
- mem_RD  in  32  memory read word; combinational from mem_A.

Behaviour:
- Reset:
  - State IDLE.
  - ready=1; done=0; err=0; rdata=0; mem_WE=0.
  - addr_q=0, so mem_A=0; merge buffer=0, so mem_WD=0.
  - Reset mid-operation aborts immediately. mem_WE falls asynchronously, so no partial write commits.
- States: IDLE, LOAD, MERGE, WRITE. ready = (state==IDLE).
- IDLE:
  - On req: latch we, funct3, addr, wdata.
  - Illegal or misaligned access: stay in IDLE; done=1, err=1 next cycle.
  - Otherwise:
    - Load goes to LOAD.
    - SW goes to WRITE; merge buffer = wdata.
    - SB/SH go to MERGE.
  - req while ready=0 is ignored; no queuing.
- Legal funct3:
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
  - Anything else is illegal.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
- LOAD:
  - Select lane from mem_RD by addr_q[1:0]: byte = bits 8*a+7:8*a; halfword = bits 16*a[1]+15:16*a[1].
  - Sign-extend for 000/001; zero-extend for 100/101.
  - Register the result into rdata; go to IDLE; done=1, err=0 next cycle.
- MERGE:
  - Merge buffer = mem_RD with the addressed byte or halfword lane replaced by wdata_q[7:0] or wdata_q[15:0].
  - Go to WRITE.
- WRITE:
  - mem_WE=1 (combinational from state); mem_WD = merge buffer.
  - Go to IDLE; done=1, err=0 next cycle.
- Latency, req accepted at edge T:
  - Load: done at T+2; rdata valid in the same cycle as done.
  - SW: mem_WE high in T+1; done at T+2.
  - SB/SH: read in T+1, write in T+2, done at T+3.
  - Error: done and err at T+1.
- done is exactly one cycle. ready returns to 1 in the same cycle as done, so back-to-back req in the done cycle is accepted.
- mem_WE is never high outside WRITE and never more than one cycle per store.
- rdata is unchanged by stores and by errors.

Decomposition:
- Shared package lsu_pkg:
  - funct3 localparams: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - State encodings: IDLE, LOAD, MERGE, WRITE.
- One combinational sub-module, lsu_lane_align:
  - Inputs: word, offset[1:0], funct3, store data.
  - Outputs: extended load value, merged store word, misalign/illegal flag.
- The FSM and registers stay in load_store_unit.

Test Plan:
- Memory word 0x10 = 0x80FF7F01; LB addr 0x13 -> done at T+2, rdata=0xFFFFFF80. LBU addr 0x12 -> 0x000000FF.
- Same word; LH addr 0x12 -> rdata=0xFFFF80FF. LHU addr 0x10 -> 0x00007F01. LW addr 0x10 -> 0x80FF7F01.
- Word 0x20 = 0x11223344; SB addr 0x21, wdata 0xAB -> mem_WE one cycle at T+2, mem_WD=0x1122AB44, done at T+3. Then SH addr 0x22, wdata 0xBEEF -> 0xBEEFAB44.
- SW addr 0x30, wdata 0xDEADBEEF -> mem_WE at T+1 only, mem_WD=0xDEADBEEF, done T+2. Follow-up LW returns the same value.
- LW addr 0x31, SH addr 0x33, and load with funct3=011 -> each gives done=err=1 at T+1; mem_WE never asserted; rdata unchanged.
- Assert rst during the WRITE cycle of an SB -> mem_WE drops immediately, target word unchanged, ready=1, all outputs at reset values. New req accepted after rst deasserts.
